byte_packing: RTL and testbench
===============================

// Module: byte_packing
// PURPOSE
//  Write-side counterpart of the LZ4 input byte-addressing unit. Collects the
//  compressor's output stream, issued as single bytes (tokens, literals, offsets)
//  or whole dwords (literal runs), and packs it MSB-first into 32-bit words for
//  the output FIFO. Flush pads the tail word with zeros and tags the last word.
// PARAMETERS
//  CNT_W     4    width of fill_cnt; the accumulator holds 0..8 bytes
//  TOTAL_W   32   width of the total byte counter
// PORTS
//  clk            in   1   system clock, rising edge
//  rstN           in   1   asynchronous reset, active low
//  wr_byte_en     in   1   append byte_in this cycle; legal only when !pack_busy
//  byte_in        in   8   byte to append
//  wr_dword_en    in   1   append dword_in, byte [31:24] first; legal only when !pack_busy
//  dword_in       in   32  dword to append
//  flush          in   1   1-cycle pulse: end of stream, drain and pad
//  pack_busy      out  1   producer must hold writes
//  fifo_full      in   1   output FIFO full
//  fifo_wr_en     out  1   write strobe to output FIFO
//  fifo_wdata     out  32  packed word, first byte in [31:24]
//  fifo_wbytes    out  3   valid bytes in fifo_wdata (1..4), left-aligned
//  fifo_wlast     out  1   final word of the stream
//  flush_done     out  1   1-cycle pulse when the flush completes
//  total_bytes    out  32  bytes accepted since reset or the last flush_done
//  wr_err         out  1   sticky: illegal write seen (busy, or byte and dword together)
// BEHAVIOUR
//  Reset: state=IDLE, acc=64'h0, fill_cnt=0, total_bytes=0, wr_err=0;
//   every output is 0 except fifo_wbytes=3'd4.
//  Accumulator acc[63:0] holds fill_cnt valid bytes left-aligned from [63:56].
//   Append writes at byte slot fill_cnt; slots already emitted are overwritten.
//  Emit (combinational from registers): fifo_wr_en = (state!=FLUSH_TAIL) &&
//   fill_cnt>=4 && !fifo_full. fifo_wdata=acc[63:32]; on emit acc<<=32, fill_cnt-=4.
//  Append and emit in the same cycle: the new byte(s) go to slot
//   fill_cnt-4*emit. Next fill_cnt = fill_cnt - 4*emit + n, n in {0,1,4}.
//  pack_busy = (fill_cnt>4) || state==FLUSH_DRAIN || state==FLUSH_TAIL.
//   Accepting at fill_cnt<=4 guarantees room for a dword (max 8 bytes).
//  Write while pack_busy: ignored, wr_err set. byte and dword together: the byte
//   is accepted, the dword is dropped, wr_err set. wr_err is cleared only by reset.
//  Byte-to-FIFO latency: a byte that completes a word is visible on fifo_wdata
//   and fifo_wr_en the next cycle (if !fifo_full).
//  FSM: IDLE -(first write)-> PACK; PACK -(flush)-> FLUSH_DRAIN.
//   A write that arrives together with flush is accepted before draining.
//   FLUSH_DRAIN: emit full words. If fill_cnt<4 and fill_cnt>0 -> FLUSH_TAIL.
//    If fill_cnt==0 -> IDLE with flush_done; in that case the last full word
//    emitted during the drain carries fifo_wlast=1 (fill_cnt was exactly 4).
//   FLUSH_TAIL: fifo_wr_en=!fifo_full, fifo_wdata=acc[63:32] with the unused low
//    bytes forced to 0, fifo_wbytes=fill_cnt, fifo_wlast=1. On the write ->
//    IDLE, flush_done=1, fill_cnt=0, total_bytes=0.
//   Flush with an empty accumulator: no FIFO write, flush_done next cycle.
//   flush in FLUSH_* states: ignored.
//  fifo_full stalls emit only. The accumulator keeps its contents; accepting
//   continues until pack_busy.
//  total_bytes wraps modulo 2^TOTAL_W.
//  rstN low mid-stream: partial data is discarded, with no tail write.
// STRUCTURE
//  Shared package/header lz4_pkg: FSM state encodings (IDLE/PACK/FLUSH_DRAIN/
//   FLUSH_TAIL, 2 bits), BYTE_W=8, WORD_BYTES=4.
//  One natural sub-module: byte_pack_merge (combinational) - slot-insert of
//   1 or 4 bytes into the 64-bit accumulator after an optional 32-bit shift.
//   The FSM, counters and flags stay in the top.
// TESTING
//  1. bytes 11,22,33,44 on 4 consecutive cycles -> one write 32'h11223344,
//     fifo_wbytes=4, fifo_wlast=0.
//  2. byte AA, dword 32'hBBCCDDEE, byte FF, flush -> writes AABBCCDD (wbytes 4),
//     then EEFF0000 (wbytes 2, wlast 1); flush_done pulse; total_bytes resets.
//  3. fifo_full held high during 8 dword bytes -> pack_busy=1 at fill 8, no write;
//     release -> two back-to-back writes in order.
//  4. wr_byte_en and wr_dword_en together -> byte kept, dword dropped, wr_err=1;
//     write while busy -> ignored.
//  5. exactly 8 bytes then flush -> second word has wlast=1, wbytes=4, no pad word;
//     flush with 0 bytes -> flush_done only.
//  6. rstN low with 3 bytes pending -> all outputs at reset values, no write;
//     resume -> new stream packs from slot 0.

Source files
------------

// File: rtl/lz4_pkg.sv
// Shared LZ4 datapath constants: byte/word geometry and packer FSM state codes.
package lz4_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;
  localparam int unsigned ACC_BYTES  = 2 * WORD_BYTES;
  localparam int unsigned ACC_W      = BYTE_W * ACC_BYTES;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PACK        = 2'd1;
  localparam logic [1:0] ST_FLUSH_DRAIN = 2'd2;
  localparam logic [1:0] ST_FLUSH_TAIL  = 2'd3;

endpackage

// File: rtl/byte_pack_merge.sv
// Accumulator update: optional one-word left shift, then insert 1 or 4 bytes
// starting at byte slot i_slot (slot 0 = bits [63:56]).
module byte_pack_merge
  import lz4_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic              i_shift,
  input  logic [CNT_W-1:0]  i_slot,
  input  logic              i_byte_en,
  input  logic              i_dword_en,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic [WORD_W-1:0] i_dword,
  output logic [ACC_W-1:0]  o_acc
);

  logic [ACC_W-1:0] w_shifted;

  always_comb begin
    w_shifted = i_shift ? {i_acc[WORD_W-1:0], WORD_W'(0)} : i_acc;
    o_acc     = w_shifted;
    for (int i = 0; i < int'(ACC_BYTES); i++) begin
      if (i_byte_en && (i_slot == CNT_W'(i))) begin
        o_acc[ACC_W-1-BYTE_W*i -: BYTE_W] = i_byte;
      end
      // dword byte k lands in lane slot+k, most significant byte first
      for (int k = 0; k < int'(WORD_BYTES); k++) begin
        if (i_dword_en && (CNT_W'(i) == (i_slot + CNT_W'(k)))) begin
          o_acc[ACC_W-1-BYTE_W*i -: BYTE_W] = i_dword[WORD_W-1-BYTE_W*k -: BYTE_W];
        end
      end
    end
  end

endmodule

// File: rtl/byte_packing.sv
// Packs a byte/dword output stream MSB-first into 32-bit FIFO words; flush
// drains, zero-pads the tail word and tags the final word.
module byte_packing
  import lz4_pkg::*;
#(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TOTAL_W = 32
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               wr_byte_en,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               wr_dword_en,
  input  logic [WORD_W-1:0]  dword_in,
  input  logic               flush,
  output logic               pack_busy,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [WORD_W-1:0]  fifo_wdata,
  output logic [2:0]         fifo_wbytes,
  output logic               fifo_wlast,
  output logic               flush_done,
  output logic [TOTAL_W-1:0] total_bytes,
  output logic               wr_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_BYTES);

  logic [1:0]         r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_fill_cnt;
  logic [TOTAL_W-1:0] r_total;
  logic               r_wr_err;

  logic [1:0]         w_state_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [ACC_W-1:0]   w_acc_merged;
  logic [CNT_W-1:0]   w_fill_nxt;
  logic [TOTAL_W-1:0] w_total_nxt;
  logic               w_wr_err_nxt;
  logic               w_tail;
  logic               w_busy;
  logic               w_emit;
  logic               w_tail_wr;
  logic               w_acc_byte;
  logic               w_acc_dword;
  logic               w_done;
  logic               w_last_full;
  logic [CNT_W-1:0]   w_slot;
  logic [WORD_W-1:0]  w_wdata;

  byte_pack_merge #(
    .CNT_W (CNT_W)
  ) u_merge (
    .i_acc      (r_acc),
    .i_shift    (w_emit),
    .i_slot     (w_slot),
    .i_byte_en  (w_acc_byte),
    .i_dword_en (w_acc_dword),
    .i_byte     (byte_in),
    .i_dword    (dword_in),
    .o_acc      (w_acc_merged)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_fill_cnt <= '0;
      r_total    <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_total    <= w_total_nxt;
      r_wr_err   <= w_wr_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tail       = (r_state == ST_FLUSH_TAIL);
    w_busy       = (r_fill_cnt > FULL_CNT) || (r_state == ST_FLUSH_DRAIN) || w_tail;
    w_emit       = !w_tail && (r_fill_cnt >= FULL_CNT) && !fifo_full;
    w_tail_wr    = w_tail && !fifo_full;
    w_acc_byte   = wr_byte_en && !w_busy;
    w_acc_dword  = wr_dword_en && !wr_byte_en && !w_busy;
    w_slot       = w_emit ? (r_fill_cnt - FULL_CNT) : r_fill_cnt;
    w_done       = ((r_state == ST_FLUSH_DRAIN) && (r_fill_cnt == '0)) || w_tail_wr;
    w_last_full  = w_emit && (r_state == ST_FLUSH_DRAIN) && (r_fill_cnt == FULL_CNT);
    w_wr_err_nxt = r_wr_err || ((wr_byte_en || wr_dword_en) && w_busy)
                 || (wr_byte_en && wr_dword_en);

    w_fill_nxt  = r_fill_cnt;
    w_total_nxt = r_total;
    if (w_emit)      w_fill_nxt = w_fill_nxt - FULL_CNT;
    if (w_acc_byte)  w_fill_nxt = w_fill_nxt + CNT_W'(1);
    if (w_acc_dword) w_fill_nxt = w_fill_nxt + FULL_CNT;
    if (w_acc_byte)  w_total_nxt = r_total + TOTAL_W'(1);
    if (w_acc_dword) w_total_nxt = r_total + TOTAL_W'(WORD_BYTES);
    w_acc_nxt = w_acc_merged;
    if (w_done) begin
      w_fill_nxt  = '0;
      w_total_nxt = '0;
      w_acc_nxt   = '0;
    end

    case (r_state)
      ST_IDLE: begin
        if (flush)                          w_state_nxt = ST_FLUSH_DRAIN;
        else if (w_acc_byte || w_acc_dword) w_state_nxt = ST_PACK;
      end
      ST_PACK: begin
        if (flush) w_state_nxt = ST_FLUSH_DRAIN;
      end
      ST_FLUSH_DRAIN: begin
        if (r_fill_cnt == '0)          w_state_nxt = ST_IDLE;
        else if (r_fill_cnt < FULL_CNT) w_state_nxt = ST_FLUSH_TAIL;
      end
      ST_FLUSH_TAIL: begin
        if (!fifo_full) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // tail word keeps only the fill_cnt leading bytes
    w_wdata = r_acc[ACC_W-1 -: WORD_W];
    if (w_tail) begin
      for (int k = 0; k < int'(WORD_BYTES); k++) begin
        if (CNT_W'(k) >= r_fill_cnt) w_wdata[WORD_W-1-BYTE_W*k -: BYTE_W] = '0;
      end
    end
  end

  assign pack_busy   = w_busy;
  assign fifo_wr_en  = w_emit || w_tail_wr;
  assign fifo_wdata  = w_wdata;
  assign fifo_wbytes = w_tail ? r_fill_cnt[2:0] : 3'(WORD_BYTES);
  assign fifo_wlast  = w_tail || w_last_full;
  assign flush_done  = w_done;
  assign total_bytes = r_total;
  assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_byte_packing.sv
// Directed and randomized checks of byte_packing against a byte-queue model.
module tb_byte_packing;

  logic        clk = 1'b0;
  logic        rstN;
  logic        wr_byte_en;
  logic [7:0]  byte_in;
  logic        wr_dword_en;
  logic [31:0] dword_in;
  logic        flush;
  logic        pack_busy;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_wdata;
  logic [2:0]  fifo_wbytes;
  logic        fifo_wlast;
  logic        flush_done;
  logic [31:0] total_bytes;
  logic        wr_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [35:0] cap_q[$];
  logic [7:0]  model_q[$];
  int          n_wr, guard, nw, nb;
  logic [31:0] rd, exp_w;

  byte_packing dut (
    .clk         (clk),
    .rstN        (rstN),
    .wr_byte_en  (wr_byte_en),
    .byte_in     (byte_in),
    .wr_dword_en (wr_dword_en),
    .dword_in    (dword_in),
    .flush       (flush),
    .pack_busy   (pack_busy),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wdata  (fifo_wdata),
    .fifo_wbytes (fifo_wbytes),
    .fifo_wlast  (fifo_wlast),
    .flush_done  (flush_done),
    .total_bytes (total_bytes),
    .wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  // FIFO-side monitor: {wlast, wbytes, wdata} of every accepted write
  always @(negedge clk) begin
    if (fifo_wr_en) cap_q.push_back({fifo_wlast, fifo_wbytes, fifo_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_byte_en  = 1'b0;
    wr_dword_en = 1'b0;
    flush       = 1'b0;
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    byte_in    = b;
    wr_byte_en = 1'b1;
    step();
  endtask

  task automatic put_dword(input logic [31:0] d);
    dword_in    = d;
    wr_dword_en = 1'b1;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, fifo_wr_en, 0);
    check({tag, "_wdata"}, fifo_wdata, 0);
    check({tag, "_wbytes"}, fifo_wbytes, 4);
    check({tag, "_wlast"}, fifo_wlast, 0);
    check({tag, "_busy"}, pack_busy, 0);
    check({tag, "_flush_done"}, flush_done, 0);
    check({tag, "_total"}, total_bytes, 0);
    check({tag, "_wr_err"}, wr_err, 0);
  endtask

  initial begin
    rstN = 1'b0; wr_byte_en = 1'b0; byte_in = '0; wr_dword_en = 1'b0;
    dword_in = '0; flush = 1'b0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rstN = 1'b1;
    step();

    // 1: four single bytes make one full word
    cap_q.delete();
    put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
    check("t1_wr_en", fifo_wr_en, 1);
    check("t1_wdata", fifo_wdata, 32'h11223344);
    check("t1_wbytes", fifo_wbytes, 4);
    check("t1_wlast", fifo_wlast, 0);
    check("t1_total", total_bytes, 4);
    step();
    check("t1_idle_wr_en", fifo_wr_en, 0);
    flush = 1'b1; step();
    check("t1_flush_done", flush_done, 1);
    step();
    check("t1_total_clr", total_bytes, 0);
    check("t1_nwords", cap_q.size(), 1);

    // 2: byte, dword, byte, flush -> full word then padded tail
    cap_q.delete();
    put_byte(8'hAA);
    put_dword(32'hBBCCDDEE);
    check("t2_busy_at5", pack_busy, 1);
    check("t2_w0", fifo_wdata, 32'hAABBCCDD);
    step();
    check("t2_busy_at1", pack_busy, 0);
    put_byte(8'hFF);
    flush = 1'b1; step();
    check("t2_drain_wr_en", fifo_wr_en, 0);
    step();
    check("t2_tail_wr_en", fifo_wr_en, 1);
    check("t2_tail_wdata", fifo_wdata, 32'hEEFF0000);
    check("t2_tail_wbytes", fifo_wbytes, 2);
    check("t2_tail_wlast", fifo_wlast, 1);
    check("t2_tail_done", flush_done, 1);
    check("t2_total6", total_bytes, 6);
    step();
    check("t2_done_pulse", flush_done, 0);
    check("t2_total_clr", total_bytes, 0);
    check("t2_nwords", cap_q.size(), 2);

    // 3: stalled FIFO fills the accumulator, then two back-to-back writes
    cap_q.delete();
    fifo_full = 1'b1;
    put_dword(32'h11223344);
    check("t3_stall_wr_en", fifo_wr_en, 0);
    put_dword(32'h55667788);
    check("t3_busy_at8", pack_busy, 1);
    check("t3_stall_wr_en8", fifo_wr_en, 0);
    fifo_full = 1'b0; #1;
    check("t3_w0_en", fifo_wr_en, 1);
    check("t3_w0", fifo_wdata, 32'h11223344);
    step();
    check("t3_w1_en", fifo_wr_en, 1);
    check("t3_w1", fifo_wdata, 32'h55667788);
    step();
    check("t3_after_en", fifo_wr_en, 0);
    check("t3_nwords", cap_q.size(), 2);
    flush = 1'b1; step();
    check("t3_flush_done", flush_done, 1);
    step();

    // 5: exactly eight bytes with flush on the last -> tagged full word, no pad
    cap_q.delete();
    for (int i = 1; i <= 7; i++) put_byte(8'(i));
    byte_in = 8'h08; wr_byte_en = 1'b1; flush = 1'b1; step();
    check("t5_w1_en", fifo_wr_en, 1);
    check("t5_w1", fifo_wdata, 32'h05060708);
    check("t5_w1_last", fifo_wlast, 1);
    check("t5_w1_bytes", fifo_wbytes, 4);
    step();
    check("t5_done", flush_done, 1);
    check("t5_done_no_wr", fifo_wr_en, 0);
    step();
    check("t5_nwords", cap_q.size(), 2);
    if (cap_q.size() > 0) check("t5_w0", cap_q[0], {1'b0, 3'd4, 32'h01020304});
    flush = 1'b1; step();
    check("t5_empty_done", flush_done, 1);
    check("t5_empty_no_wr", fifo_wr_en, 0);
    step();
    check("t5_empty_nwords", cap_q.size(), 2);

    // random stream with FIFO back-pressure, flush on the last write
    cap_q.delete();
    model_q.delete();
    n_wr = int'($urandom_range(40, 10));
    for (int k = 0; k < n_wr; k++) begin
      guard = 0;
      while (pack_busy && guard < 100) begin
        fifo_full = ($urandom_range(3) == 0);
        step();
        guard++;
      end
      if (guard >= 100) check("rand_busy_timeout", pack_busy, 0);
      if (k == n_wr - 1) check("rand_total", total_bytes, model_q.size());
      if ($urandom_range(1) == 0) begin
        byte_in = 8'($urandom);
        wr_byte_en = 1'b1;
        model_q.push_back(byte_in);
      end else begin
        dword_in = $urandom;
        wr_dword_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
          rd = dword_in << (8 * j);
          model_q.push_back(rd[31:24]);
        end
      end
      flush = (k == n_wr - 1);
      fifo_full = ($urandom_range(3) == 0);
      step();
      if ($urandom_range(3) == 0) begin
        fifo_full = ($urandom_range(3) == 0);
        step();
      end
    end
    guard = 0;
    while (guard < 200) begin
      fifo_full = ($urandom_range(3) == 0);
      #1;
      if (flush_done) break;
      step();
      guard++;
    end
    check("rand_flush_done", flush_done, 1);
    fifo_full = 1'b0;
    step();
    check("rand_total_clr", total_bytes, 0);
    nb = model_q.size();
    nw = (nb + 3) / 4;
    check("rand_nwords", cap_q.size(), nw);
    for (int i = 0; i < nw && i < cap_q.size(); i++) begin
      exp_w = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * i + j < nb) exp_w[31-8*j -: 8] = model_q[4*i+j];
      end
      check($sformatf("rand_word%0d", i), cap_q[i],
            {(i == nw - 1), 3'((nb - 4 * i) > 4 ? 4 : (nb - 4 * i)), exp_w});
    end

    // 4: byte+dword together keeps the byte; writes while busy are ignored
    cap_q.delete();
    byte_in = 8'h5A; dword_in = 32'hDEADBEEF;
    wr_byte_en = 1'b1; wr_dword_en = 1'b1; step();
    check("t4_wr_err", wr_err, 1);
    check("t4_total1", total_bytes, 1);
    fifo_full = 1'b1;
    put_dword(32'h01020304);
    check("t4_busy", pack_busy, 1);
    put_byte(8'h99);
    check("t4_busy_ignored", total_bytes, 5);
    fifo_full = 1'b0; step();
    flush = 1'b1; step();
    step();
    check("t4_tail", fifo_wdata, 32'h04000000);
    check("t4_tail_bytes", fifo_wbytes, 1);
    check("t4_tail_last", fifo_wlast, 1);
    step();
    check("t4_nwords", cap_q.size(), 2);
    if (cap_q.size() > 0) check("t4_w0", cap_q[0], {1'b0, 3'd4, 32'h5A010203});
    check("t4_err_sticky", wr_err, 1);

    // 6: reset mid-stream discards partial data without a tail write
    cap_q.delete();
    put_byte(8'hA1); put_byte(8'hA2); put_byte(8'hA3);
    rstN = 1'b0; #1;
    check_reset_outputs("t6_rst");
    step(); step();
    check("t6_no_write", cap_q.size(), 0);
    rstN = 1'b1;
    step();
    put_byte(8'hC1); put_byte(8'hC2); put_byte(8'hC3); put_byte(8'hC4);
    check("t6_resume_en", fifo_wr_en, 1);
    check("t6_resume_word", fifo_wdata, 32'hC1C2C3C4);
    check("t6_resume_total", total_bytes, 4);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
